// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: widths, Annex K quantisation tables,
// their reciprocals, and the row-major to zig-zag position map.
package jpeg_pkg;

  localparam int CW = 12;
  localparam int QW = 11;
  localparam int RW = 16;
  localparam int PW = RW + 1;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;
  localparam logic [1:0] COMP_X  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  typedef logic [0:63][7:0]    qtab_t;
  typedef logic [0:63][PW-1:0] rtab_t;
  typedef logic [0:63][5:0]    zmap_t;

  localparam qtab_t Q_LUMA = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68,109,103, 77,
    24, 35, 55, 64, 81,104,113, 92,
    49, 64, 78, 87,103,121,120,101,
    72, 92, 95, 98,112,100,103, 99
  };

  localparam qtab_t Q_CHROMA = '{
    17, 18, 24, 47, 99, 99, 99, 99,
    18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,
    47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99
  };

  localparam zmap_t ZZ = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

  // Elaboration-time only: round(2^RW / q)
  function automatic rtab_t mk_recip(input qtab_t q);
    rtab_t r;
    for (int i = 0; i < 64; i++) begin
      r[i] = PW'(((1 << RW) + int'(q[i]) / 2) / int'(q[i]));
    end
    return r;
  endfunction

  localparam rtab_t R_LUMA   = mk_recip(Q_LUMA);
  localparam rtab_t R_CHROMA = mk_recip(Q_CHROMA);

endpackage

// File: rtl/quant_mult.sv
// Sign-magnitude reciprocal multiply, round half away from zero,
// saturate to QW bits, one output register.
module quant_mult #(
  parameter int CW = 12,
  parameter int QW = 11,
  parameter int RW = 16,
  parameter int PW = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic signed [CW-1:0] coef,
  input  logic [PW-1:0]        recip,
  output logic signed [QW-1:0] q
);

  localparam int MW = CW + PW;
  localparam int SW = MW - RW;
  localparam logic [SW-1:0] POS_MAX = SW'((1 << (QW - 1)) - 1);
  localparam logic [SW-1:0] NEG_MAX = SW'(1 << (QW - 1));
  localparam logic [MW-1:0] HALF = MW'(1 << (RW - 1));

  logic          neg;
  logic [CW-1:0] mag;
  logic [MW-1:0] prod;
  logic [SW-1:0] res;
  logic [SW-1:0] nres;
  logic [QW-1:0] sat;

  // CW-bit magnitude so the most negative input stays exact
  always_comb begin
    neg  = coef[CW-1];
    mag  = neg ? (~$unsigned(coef) + CW'(1)) : $unsigned(coef);
    prod = MW'(mag) * MW'(recip) + HALF;
    res  = prod[MW-1:RW];
    nres = ~res + SW'(1);
    sat  = '0;
    if (!neg) begin
      sat = (res > POS_MAX) ? POS_MAX[QW-1:0] : res[QW-1:0];
    end else begin
      sat = (res > NEG_MAX) ? NEG_MAX[QW-1:0] : nres[QW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= $signed(sat);
    end
  end

endmodule

// File: rtl/quant_zigzag.sv
// JPEG quantiser: 64 row-major coefficients in, quantised
// values out in zig-zag order with a done pulse per block.
module quant_zigzag
  import jpeg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           comp_sel,
  input  logic                 coef_valid,
  input  logic signed [CW-1:0] coef_in,
  output logic                 coef_ready,
  output logic                 q_valid,
  input  logic                 q_ready,
  output logic signed [QW-1:0] q_out,
  output logic [5:0]           zz_idx,
  output logic                 done
);

  state_t               state;
  logic [5:0]           in_cnt;
  logic                 chroma;
  logic                 acc;
  logic                 wr_en;
  logic [5:0]           wr_addr;
  logic [PW-1:0]        recip;
  logic signed [QW-1:0] res;
  logic signed [QW-1:0] qbuf [64];

  assign acc   = coef_valid & coef_ready;
  assign recip = chroma ? R_CHROMA[in_cnt] : R_LUMA[in_cnt];

  quant_mult #(
    .CW(CW),
    .QW(QW),
    .RW(RW),
    .PW(PW)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (acc),
    .coef  (coef_in),
    .recip (recip),
    .q     (res)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      qbuf[wr_addr] <= res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_cnt     <= '0;
      chroma     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      coef_ready <= 1'b0;
      q_valid    <= 1'b0;
      q_out      <= '0;
      zz_idx     <= '0;
      done       <= 1'b0;
    end else begin
      wr_en   <= acc;
      wr_addr <= ZZ[in_cnt];
      done    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (enable) begin
            state      <= S_LOAD;
            in_cnt     <= '0;
            coef_ready <= 1'b1;
            chroma     <= (comp_sel == COMP_CB) ||
                          (comp_sel == COMP_CR) ||
                          (comp_sel == COMP_X);
          end
        end
        S_LOAD: begin
          if (acc) begin
            in_cnt <= in_cnt + 6'd1;
            if (in_cnt == 6'd63) begin
              coef_ready <= 1'b0;
              state      <= S_DRAIN;
            end
          end
        end
        // last write lands at zz 63, so qbuf[0] is already final
        S_DRAIN: begin
          state   <= S_OUT;
          q_valid <= 1'b1;
          q_out   <= qbuf[0];
          zz_idx  <= '0;
        end
        S_OUT: begin
          if (q_ready) begin
            if (zz_idx == 6'd63) begin
              q_valid <= 1'b0;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              zz_idx <= zz_idx + 6'd1;
              q_out  <= qbuf[zz_idx + 6'd1];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
